// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative M-extension multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] M_FUNCT7 = 7'b0000001;
   localparam logic [1:0] ALUOP_R  = 2'b10;

   // funct3[2] separates the divide group from the multiply group.
   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result selection, shared by the multiply and divide paths.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        funct3,
   input  logic [2*XLEN-1:0] acc,
   input  logic              neg_main,
   input  logic              neg_rem,
   output logic [XLEN-1:0]   result
);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;

   // Divide path keeps {remainder, quotient} in the same accumulator as the product.
   always_comb begin
      prod   = neg_main ? -acc : acc;
      quot   = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem    = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      result = rem;
      case (funct3)
         F3_MUL:                        result = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               result = quot;
         default:                       result = rem;
      endcase
   end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply (IDLE->FIX->DONE).
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// MUL     | one shift-add multiply step per cycle
// DIV     | one restoring divide step per cycle
// FIX     | sign correction and result select
// DONE    | result held until out_ready
module muldiv_seq_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [2:0]          f3_q, f3_d;
   logic                neg_main_q, neg_main_d;
   logic                neg_rem_q, neg_rem_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                illegal_q, illegal_d;
   logic [XLEN-1:0]     result_q, result_d;
`ifndef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
`endif

   logic                m_op, sgn_a, sgn_b, neg_a, neg_b, div_ovf;
   logic [XLEN-1:0]     op_a, op_b, fix_res;
   logic [XLEN:0]       div_shl, div_diff;

   always_comb begin
      m_op    = (ALUOp == ALUOP_R) && (funct7 == M_FUNCT7);
      sgn_a   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV)  || (funct3 == F3_REM);
      sgn_b   = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
      neg_a   = sgn_a && rs1[XLEN-1];
      neg_b   = sgn_b && rs2[XLEN-1];
      op_a    = neg_a ? -rs1 : rs1;
      op_b    = neg_b ? -rs2 : rs2;
      div_ovf = sgn_b && is_div_op(funct3) &&
                (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
      // Restoring step: shift {rem, quot} left by one, trial-subtract the divisor.
      div_shl  = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_shl - {1'b0, opb_q};
   end

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .funct3   (f3_q),
      .acc      (acc_q),
      .neg_main (neg_main_q),
      .neg_rem  (neg_rem_q),
      .result   (fix_res)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      f3_d       = f3_q;
      neg_main_d = neg_main_q;
      neg_rem_d  = neg_rem_q;
      illegal_d  = illegal_q;
      result_d   = result_q;
`ifndef MULDIV_FAST_MUL_EN
      mcand_d    = mcand_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               f3_d       = funct3;
               neg_main_d = neg_a ^ neg_b;
               neg_rem_d  = neg_a;
               cnt_d      = CNT_W'(XLEN);
               illegal_d  = 1'b0;
               if (!m_op) begin
                  state_d   = ST_DONE;
                  result_d  = '0;
                  illegal_d = 1'b1;
               end else if (is_div_op(funct3) && (rs2 == '0)) begin
                  state_d  = ST_DONE;
                  result_d = funct3[1] ? rs1 : {XLEN{1'b1}};
               end else if (div_ovf) begin
                  state_d  = ST_DONE;
                  result_d = funct3[1] ? '0 : rs1;
               end else if (is_div_op(funct3)) begin
                  state_d = ST_DIV;
                  acc_d   = {{XLEN{1'b0}}, op_a};
                  opb_d   = op_b;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  state_d = ST_FIX;
                  acc_d   = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};
`else
                  state_d = ST_MUL;
                  acc_d   = '0;
                  mcand_d = {{XLEN{1'b0}}, op_a};
                  opb_d   = op_b;
`endif
               end
            end
         end
`ifndef MULDIV_FAST_MUL_EN
         ST_MUL: begin
            if (opb_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
         end
`endif
         ST_DIV: begin
            if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else                 acc_d = {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            result_d = fix_res;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         f3_q        <= '0;
         neg_main_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         result_q    <= '0;
`ifndef MULDIV_FAST_MUL_EN
         mcand_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         f3_q        <= f3_d;
         neg_main_q  <= neg_main_d;
         neg_rem_q   <= neg_rem_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
         result_q    <= result_d;
`ifndef MULDIV_FAST_MUL_EN
         mcand_q     <= mcand_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign illegal   = illegal_q;

endmodule
